nibble_serial_addsub_ctrl: RTL and testbench

Sequencer that performs a wide add/subtract, 4*NIBBLES bits, by running one shared 4-bit add/sub stage once per cycle.
- Work proceeds least-significant nibble first, with the carry held in a register between cycles.
- Uses the same operand-invert plus carry-in-equals-mode scheme as the 4-bit adder/subtractor stage.
- Sits between a requesting datapath and the 4-bit stage, and provides a start/busy/done handshake.

---
 rtl/nibble_serial_addsub_ctrl_if.sv | 28 ++
 rtl/nibble_serial_addsub_ctrl.sv | 102 ++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/response bundle between a requesting datapath and the nibble-serial
// add/sub sequencer: operands and mode in, busy/done status and result out.
`timescale 1ns/1ps
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         co;
  logic         ovf;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, co, ovf
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, co, ovf
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide add/subtract sequenced through one shared 4-bit add/sub stage, LS nibble
// first, with the inter-nibble carry held in a register.
//
//   state | meaning
//   IDLE  | waiting for start; result/co/ovf hold the last answer
//   RUN   | one nibble processed per edge, idx = nibble being processed
//   DONE  | one-cycle done pulse; a start here is accepted as in IDLE
`timescale 1ns/1ps
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_serial_addsub_ctrl_if.slave  bus
);
  localparam int                IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0]   LAST = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [NIBBLES-1:0][3:0]  a_l, b_l, res_q;
  logic                     mode_l, carry_q, co_q, ovf_q;
  logic [IDXW-1:0]          idx;
  logic                     accept, last_nib;
  logic                     busy_d, done_d;
  logic [3:0]               a_nib, b_nib, sum_nib, low;
  logic [1:0]               top;

  assign accept   = bus.start && (state != RUN);
  assign last_nib = (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_nib)  state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state)
      RUN:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Shared stage split at bit 3 so the carry into the MSB is visible for ovf.
  always_comb begin
    a_nib   = a_l[idx];
    b_nib   = b_l[idx] ^ {4{mode_l}};
    low     = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
    top     = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, low[3]};
    sum_nib = {top[0], low[2:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_l     <= '0;
      b_l     <= '0;
      mode_l  <= 1'b0;
      carry_q <= 1'b0;
      idx     <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_l     <= bus.a;
      b_l     <= bus.b;
      mode_l  <= bus.mode;
      carry_q <= bus.mode;
      idx     <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state == RUN) begin
      res_q[idx] <= sum_nib;
      carry_q    <= top[1];
      idx        <= idx + IDXW'(1);
      if (last_nib) begin
        co_q  <= top[1];
        ovf_q <= low[3] ^ top[1];
      end
    end
  end

  assign bus.busy   = busy_d;
  assign bus.done   = done_d;
  assign bus.result = res_q;
  assign bus.co     = co_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for the nibble-serial add/sub sequencer, NIBBLES=4, with
// hand-computed results, latency, back-to-back and mid-run reset checks.
`timescale 1ns/1ps
module tb_nibble_serial_addsub_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  nibble_serial_addsub_ctrl_if #(.NIBBLES(4)) bus ();

  nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request while clk is low, let one edge accept it, then scramble
  // the inputs so any use of unlatched operands shows up in the result.
  task automatic issue(input logic m, input logic [15:0] ia, input logic [15:0] ib);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a     = ia;
    bus.b     = ib;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mode  = ~m;
    bus.a     = ~ia;
    bus.b     = ia ^ ib;
  endtask

  // Returns on the low phase in which done is seen.  inject_at >= 0 pulses a
  // conflicting start for one edge while the operation is running.
  task automatic wait_done(input string tag, input logic [15:0] er, input logic eco,
                           input logic eovf, input int inject_at);
    int busy_n = 0;
    int edges  = 0;
    bit seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (i == inject_at) begin
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
      end else if (i == inject_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen  = 1'b1;
        edges = i + 1;
      end
    end
    bus.start = 1'b0;
    chk({tag, " done_seen"},   32'(seen),   32'd1);
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'd4);
    chk({tag, " done_edges"},  32'(edges),  32'd5);
    chk({tag, " result"},      32'(bus.result), 32'(er));
    chk({tag, " co"},          32'(bus.co),     32'(eco));
    chk({tag, " ovf"},         32'(bus.ovf),    32'(eovf));
  endtask

  task automatic quiet_after(input string tag, input logic [15:0] er);
    @(negedge clk);
    chk({tag, " done_single"}, 32'(bus.done),   32'd0);
    chk({tag, " busy_idle"},   32'(bus.busy),   32'd0);
    chk({tag, " result_hold"}, 32'(bus.result), 32'(er));
  endtask

  initial begin
    int late_done;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    #2;
    chk("reset busy",   32'(bus.busy),   32'd0);
    chk("reset done",   32'(bus.done),   32'd0);
    chk("reset result", 32'(bus.result), 32'd0);
    chk("reset co",     32'(bus.co),     32'd0);
    chk("reset ovf",    32'(bus.ovf),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 16'h1234, 16'h0FFF);
    wait_done("add", 16'h2233, 1'b0, 1'b0, -1);
    quiet_after("add", 16'h2233);

    issue(1'b1, 16'h0005, 16'h0007);
    wait_done("sub_borrow", 16'hFFFE, 1'b0, 1'b0, -1);
    quiet_after("sub_borrow", 16'hFFFE);

    issue(1'b0, 16'h7FFF, 16'h0001);
    wait_done("add_ovf", 16'h8000, 1'b0, 1'b1, -1);
    quiet_after("add_ovf", 16'h8000);

    issue(1'b1, 16'h8000, 16'h0001);
    wait_done("sub_ovf", 16'h7FFF, 1'b1, 1'b1, -1);
    quiet_after("sub_ovf", 16'h7FFF);

    issue(1'b0, 16'h1111, 16'h2222);
    wait_done("ignore_busy", 16'h3333, 1'b0, 1'b0, 1);
    issue(1'b0, 16'hFFFF, 16'h0001);
    chk("b2b busy",    32'(bus.busy),   32'd1);
    chk("b2b done",    32'(bus.done),   32'd0);
    chk("b2b cleared", 32'(bus.result), 32'd0);
    wait_done("b2b", 16'h0000, 1'b1, 1'b0, -1);
    quiet_after("b2b", 16'h0000);

    issue(1'b0, 16'h1234, 16'h0FFF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort partial", 32'(bus.result), 32'h0033);
    chk("abort busy_pre", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy",   32'(bus.busy),   32'd0);
    chk("abort done",   32'(bus.done),   32'd0);
    chk("abort result", 32'(bus.result), 32'd0);
    chk("abort co",     32'(bus.co),     32'd0);
    chk("abort ovf",    32'(bus.ovf),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) late_done++;
    end
    chk("abort no_done", 32'(late_done), 32'd0);

    issue(1'b1, 16'h1234, 16'h1234);
    wait_done("sub_equal", 16'h0000, 1'b1, 1'b0, -1);
    quiet_after("sub_equal", 16'h0000);

    issue(1'b1, 16'h0003, 16'h8000);
    wait_done("sub_negovf", 16'h8003, 1'b0, 1'b1, -1);
    quiet_after("sub_negovf", 16'h8003);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
